// File: rtl/pixel_position_counter.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_position_counter
//  Purpose  : Tracks the (x, y) coordinate of every accepted pixel of a camera
//             frame. Honours start-of-line / start-of-frame qualifiers, pulses
//             on line and frame ends, and flags when a census window of radius
//             WIN_RADIUS ending at the current pixel is fully available,
//             reporting that window's centre coordinate.
//  Revision : 1.0 - initial parametrised two-axis release
// ----------------------------------------------------------------------------
//  Ports
//    pixelclock   in   1        pixel clock, rising-edge active
//    reset        in   1        asynchronous, active-high reset
//    pixel_valid  in   1        a pixel is presented this cycle
//    line_sync    in   1        presented pixel is first of a line
//    frame_sync   in   1        presented pixel is first of a frame (wins)
//    x            out  X_WIDTH  column of last accepted pixel
//    y            out  Y_WIDTH  row of last accepted pixel
//    pix_strobe   out  1        pulse: x/y updated
//    line_end     out  1        pulse: last accepted pixel ended a line
//    frame_end    out  1        pulse: last accepted pixel ended the frame
//    window_valid out  1        pulse: last accepted pixel completes a window
//    center_x     out  X_WIDTH  window centre column (held between windows)
//    center_y     out  Y_WIDTH  window centre row (held between windows)
//    overrun      out  1        sticky: frame ran past FRAME_LINES
// ============================================================================
module pixel_position_counter #(
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 10,
  parameter int LINE_PIXELS = 640,
  parameter int FRAME_LINES = 480,
  parameter int WIN_RADIUS  = 3,
  parameter int AUTO_WRAP   = 1
) (
  input  logic               pixelclock,
  input  logic               reset,
  input  logic               pixel_valid,
  input  logic               line_sync,
  input  logic               frame_sync,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               pix_strobe,
  output logic               line_end,
  output logic               frame_end,
  output logic               window_valid,
  output logic [X_WIDTH-1:0] center_x,
  output logic [Y_WIDTH-1:0] center_y,
  output logic               overrun
);

  localparam logic [X_WIDTH-1:0] C_LAST_X    = X_WIDTH'(LINE_PIXELS - 1);
  localparam logic [Y_WIDTH-1:0] C_LAST_Y    = Y_WIDTH'(FRAME_LINES - 1);
  // One bit wider than y: the pending row may legitimately equal FRAME_LINES,
  // which can be 2^Y_WIDTH.
  localparam logic [Y_WIDTH:0]   C_ROW_LIMIT = (Y_WIDTH + 1)'(FRAME_LINES);
  localparam logic [X_WIDTH-1:0] C_SPAN_X    = X_WIDTH'(2 * WIN_RADIUS);
  localparam logic [Y_WIDTH-1:0] C_SPAN_Y    = Y_WIDTH'(2 * WIN_RADIUS);
  localparam logic [X_WIDTH-1:0] C_RAD_X     = X_WIDTH'(WIN_RADIUS);
  localparam logic [Y_WIDTH-1:0] C_RAD_Y     = Y_WIDTH'(WIN_RADIUS);

  // Coordinate the next plain (unqualified) pixel will receive.
  logic [X_WIDTH-1:0] r_nx;
  logic [Y_WIDTH:0]   r_ny;

  logic [X_WIDTH-1:0] w_cx;
  logic [Y_WIDTH:0]   w_row_raw;
  logic               w_row_ovf;
  logic [Y_WIDTH-1:0] w_cy;
  logic               w_ovr_set;
  logic               w_line_last;
  logic               w_frame_last;
  logic               w_win_full;
  logic [X_WIDTH-1:0] w_nx_next;
  logic [Y_WIDTH:0]   w_ny_next;
  logic               w_overrun_next;

  // Coordinate of the presented pixel before the row-overflow rule.
  always_comb begin
    w_cx      = r_nx;
    w_row_raw = r_ny;
    if (frame_sync) begin
      w_cx      = '0;
      w_row_raw = '0;
    end else if (line_sync) begin
      w_cx = '0;
      // A line_sync landing exactly on a line boundary must not skip a row.
      w_row_raw = (r_nx == '0) ? r_ny : r_ny + 1'b1;
    end
  end

  assign w_row_ovf = (w_row_raw == C_ROW_LIMIT);

  generate
    if (AUTO_WRAP != 0) begin : g_wrap
      assign w_cy      = w_row_ovf ? '0 : w_row_raw[Y_WIDTH-1:0];
      assign w_ovr_set = 1'b0;
    end else begin : g_saturate
      assign w_cy      = w_row_ovf ? C_LAST_Y : w_row_raw[Y_WIDTH-1:0];
      assign w_ovr_set = w_row_ovf;
    end
  endgenerate

  assign w_line_last  = (w_cx == C_LAST_X);
  assign w_frame_last = w_line_last && (w_cy == C_LAST_Y);
  assign w_win_full   = (w_cx >= C_SPAN_X) && (w_cy >= C_SPAN_Y);

  // After the last column the row advances; overflow is resolved only when
  // that pending row is consumed by the next pixel.
  always_comb begin
    w_nx_next = w_cx + 1'b1;
    w_ny_next = {1'b0, w_cy};
    if (w_line_last) begin
      w_nx_next = '0;
      w_ny_next = {1'b0, w_cy} + 1'b1;
    end
  end

  // A frame_sync pixel clears the sticky flag on its own output update.
  assign w_overrun_next = frame_sync ? 1'b0 : (overrun | w_ovr_set);

  always_ff @(posedge pixelclock or posedge reset) begin
    if (reset) begin
      r_nx         <= '0;
      r_ny         <= '0;
      x            <= '0;
      y            <= '0;
      pix_strobe   <= 1'b0;
      line_end     <= 1'b0;
      frame_end    <= 1'b0;
      window_valid <= 1'b0;
      center_x     <= '0;
      center_y     <= '0;
      overrun      <= 1'b0;
    end else begin
      pix_strobe   <= pixel_valid;
      line_end     <= pixel_valid && w_line_last;
      frame_end    <= pixel_valid && w_frame_last;
      window_valid <= pixel_valid && w_win_full;
      if (pixel_valid) begin
        r_nx    <= w_nx_next;
        r_ny    <= w_ny_next;
        x       <= w_cx;
        y       <= w_cy;
        overrun <= w_overrun_next;
        if (w_win_full) begin
          center_x <= w_cx - C_RAD_X;
          center_y <= w_cy - C_RAD_Y;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_position_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_position_counter
//  Purpose  : Directed bench for pixel_position_counter. Two instances share
//             the stimulus: index 0 saturates (AUTO_WRAP=0), index 1 wraps
//             (AUTO_WRAP=1). A reference model pushes the expected outputs of
//             each driven cycle onto a per-instance queue; they are popped and
//             compared one cycle later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_position_counter;

  localparam int XW = 4;
  localparam int YW = 4;
  localparam int LP = 4;
  localparam int FL = 3;
  localparam int R  = 1;

  typedef struct {
    int x; int y; int ps; int le; int fe; int wv; int cx; int cy; int ov;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic pv    = 1'b0;
  logic ls    = 1'b0;
  logic fs    = 1'b0;

  logic [XW-1:0] xo   [2];
  logic [YW-1:0] yo   [2];
  logic          pso  [2];
  logic          leo  [2];
  logic          feo  [2];
  logic          wvo  [2];
  logic [XW-1:0] cxo  [2];
  logic [YW-1:0] cyo  [2];
  logic          ovo  [2];

  int total = 0;
  int bad   = 0;
  int step_no = 0;

  int   m_nx   [2];
  int   m_ny   [2];
  exp_t m_last [2];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  pixel_position_counter #(
    .X_WIDTH(XW), .Y_WIDTH(YW), .LINE_PIXELS(LP), .FRAME_LINES(FL),
    .WIN_RADIUS(R), .AUTO_WRAP(0)
  ) u_sat (
    .pixelclock(clk), .reset(reset), .pixel_valid(pv), .line_sync(ls),
    .frame_sync(fs), .x(xo[0]), .y(yo[0]), .pix_strobe(pso[0]),
    .line_end(leo[0]), .frame_end(feo[0]), .window_valid(wvo[0]),
    .center_x(cxo[0]), .center_y(cyo[0]), .overrun(ovo[0])
  );

  pixel_position_counter #(
    .X_WIDTH(XW), .Y_WIDTH(YW), .LINE_PIXELS(LP), .FRAME_LINES(FL),
    .WIN_RADIUS(R), .AUTO_WRAP(1)
  ) u_wrap (
    .pixelclock(clk), .reset(reset), .pixel_valid(pv), .line_sync(ls),
    .frame_sync(fs), .x(xo[1]), .y(yo[1]), .pix_strobe(pso[1]),
    .line_end(leo[1]), .frame_end(feo[1]), .window_valid(wvo[1]),
    .center_x(cxo[1]), .center_y(cyo[1]), .overrun(ovo[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_nx[w] = 0;
      m_ny[w] = 0;
      m_last[w] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    end
  endtask

  // Reference behaviour for one accepted pixel on instance w (w==1 wraps).
  task automatic model_accept(input int w, input bit l, input bit f, output exp_t e);
    int cx;
    int r;
    e = m_last[w];
    if (f) begin
      cx = 0; r = 0;
    end else if (l) begin
      cx = 0; r = (m_nx[w] == 0) ? m_ny[w] : m_ny[w] + 1;
    end else begin
      cx = m_nx[w]; r = m_ny[w];
    end
    if (r == FL) begin
      if (w == 1) r = 0;
      else begin r = FL - 1; e.ov = 1; end
    end
    if (f) e.ov = 0;
    e.x  = cx;
    e.y  = r;
    e.ps = 1;
    e.le = (cx == LP - 1);
    e.fe = (cx == LP - 1) && (r == FL - 1);
    e.wv = (cx >= 2 * R) && (r >= 2 * R);
    if (e.wv != 0) begin
      e.cx = cx - R;
      e.cy = r - R;
    end
    if (cx == LP - 1) begin
      m_nx[w] = 0; m_ny[w] = r + 1;
    end else begin
      m_nx[w] = cx + 1; m_ny[w] = r;
    end
    m_last[w] = e;
  endtask

  task automatic compare(input int w, input exp_t e);
    string p;
    p = (w == 0) ? "sat" : "wrap";
    check({p, ".x"},            32'(xo[w]),  32'(e.x));
    check({p, ".y"},            32'(yo[w]),  32'(e.y));
    check({p, ".pix_strobe"},   32'(pso[w]), 32'(e.ps));
    check({p, ".line_end"},     32'(leo[w]), 32'(e.le));
    check({p, ".frame_end"},    32'(feo[w]), 32'(e.fe));
    check({p, ".window_valid"}, 32'(wvo[w]), 32'(e.wv));
    check({p, ".center_x"},     32'(cxo[w]), 32'(e.cx));
    check({p, ".center_y"},     32'(cyo[w]), 32'(e.cy));
    check({p, ".overrun"},      32'(ovo[w]), 32'(e.ov));
  endtask

  task automatic check_zero(input string tag);
    for (int w = 0; w < 2; w++) begin
      check({tag, ".x"},   32'(xo[w]),  32'd0);
      check({tag, ".y"},   32'(yo[w]),  32'd0);
      check({tag, ".ps"},  32'(pso[w]), 32'd0);
      check({tag, ".le"},  32'(leo[w]), 32'd0);
      check({tag, ".fe"},  32'(feo[w]), 32'd0);
      check({tag, ".wv"},  32'(wvo[w]), 32'd0);
      check({tag, ".cx"},  32'(cxo[w]), 32'd0);
      check({tag, ".cy"},  32'(cyo[w]), 32'd0);
      check({tag, ".ov"},  32'(ovo[w]), 32'd0);
    end
  endtask

  // Drive one cycle, queue the prediction, then compare after the edge.
  task automatic step(input bit v, input bit l, input bit f);
    exp_t e;
    @(negedge clk);
    step_no++;
    pv = v; ls = l; fs = f;
    for (int w = 0; w < 2; w++) begin
      if (v) model_accept(w, l, f, e);
      else begin
        e = m_last[w];
        e.ps = 0; e.le = 0; e.fe = 0; e.wv = 0;
        m_last[w] = e;
      end
      if (w == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk);
    #1;
    e = q0.pop_front();
    compare(0, e);
    e = q1.pop_front();
    compare(1, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int le_cnt;
    int fe_cnt;
    int wv_cnt;

    // Reset state
    model_reset();
    #1 reset = 1'b1;
    #2 check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // 12 back-to-back pixels: one full 4x3 frame
    le_cnt = 0; fe_cnt = 0; wv_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0);
      le_cnt += int'(leo[1]);
      fe_cnt += int'(feo[1]);
      wv_cnt += int'(wvo[1]);
      if (i == 10) begin
        check("plan.c11_cx", 32'(cxo[1]), 32'd1);
        check("plan.c11_cy", 32'(cyo[1]), 32'd1);
      end
    end
    check("plan.le_count", 32'(le_cnt), 32'd3);
    check("plan.fe_count", 32'(fe_cnt), 32'd1);
    check("plan.wv_count", 32'(wv_cnt), 32'd2);
    check("plan.p12_x",  32'(xo[1]),  32'd3);
    check("plan.p12_y",  32'(yo[1]),  32'd2);
    check("plan.p12_cx", 32'(cxo[1]), 32'd2);

    // 13th pixel: saturate vs wrap, then valid toggled with gaps
    step(1, 0, 0);
    check("plan.sat13_y",   32'(yo[0]),  32'd2);
    check("plan.sat13_ov",  32'(ovo[0]), 32'd1);
    check("plan.wrap13_y",  32'(yo[1]),  32'd0);
    check("plan.wrap13_ov", 32'(ovo[1]), 32'd0);
    step(0, 0, 0);
    check("plan.gap_ps", 32'(pso[1]), 32'd0);
    check("plan.gap_x",  32'(xo[1]),  32'd0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 1);
    step(1, 0, 0);
    check("plan.toggle_x", 32'(xo[1]), 32'd2);
    step(0, 0, 0);

    // frame_sync clears overrun
    step(1, 0, 1);
    check("plan.fs_ov", 32'(ovo[0]), 32'd0);
    check("plan.fs_y",  32'(yo[0]),  32'd0);

    // Short line: 2 more pixels then line_sync
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    check("plan.short_x",  32'(xo[1]),  32'd0);
    check("plan.short_y",  32'(yo[1]),  32'd1);
    check("plan.short_le", 32'(leo[1]), 32'd0);

    // frame_sync on what would be (2,1)
    step(1, 0, 0);
    step(1, 0, 1);
    check("plan.fs21_x", 32'(xo[1]), 32'd0);
    check("plan.fs21_y", 32'(yo[1]), 32'd0);
    step(1, 0, 0);
    check("plan.after_fs_x", 32'(xo[1]), 32'd1);
    check("plan.after_fs_y", 32'(yo[1]), 32'd0);

    // Both syncs: frame_sync wins
    step(1, 1, 1);
    check("plan.both_y", 32'(yo[1]), 32'd0);

    // line_sync exactly at a line boundary does not skip a row
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    check("plan.ls_boundary_y", 32'(yo[1]), 32'd1);
    step(1, 0, 0);

    // Asynchronous reset mid-line, between clock edges
    @(negedge clk);
    pv = 1'b0; ls = 1'b0; fs = 1'b0;
    #2 reset = 1'b1;
    #1 check_zero("midreset");
    model_reset();
    #1 reset = 1'b0;
    step(1, 0, 0);
    check("plan.post_reset_x", 32'(xo[1]), 32'd0);
    check("plan.post_reset_y", 32'(yo[1]), 32'd0);
    step(1, 0, 0);

    check("queue.sat_empty",  32'(q0.size()), 32'd0);
    check("queue.wrap_empty", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_position_counter.md
Name: pixel_position_counter

Overview:
- Parametrised successor to the single-axis pixel counter: tracks the (x, y) coordinate of every accepted pixel in a frame.
- Honours start-of-line and start-of-frame qualifiers and flags line and frame ends.
- Asserts window_valid when a census window of radius WIN_RADIUS is fully available, and reports that window's centre coordinate.
- Sits at the head of the stereo census pipeline, fed by the camera pixel interface.

Parameters:
X_WIDTH, 10, width of x/center_x outputs
Y_WIDTH, 10, width of y/center_y outputs
LINE_PIXELS, 640, pixels per nominal line (must be <= 2^X_WIDTH)
FRAME_LINES, 480, lines per nominal frame (must be <= 2^Y_WIDTH)
WIN_RADIUS, 3, census window radius R (2R < LINE_PIXELS and 2R < FRAME_LINES)
AUTO_WRAP, 1, 1: y wraps to 0 after the last line; 0: y saturates and flags overrun

Ports:
pixelclock  input  1  pixel clock, rising-edge active
reset  input  1  reset, asynchronous, active-high
pixel_valid  input  1  a pixel is presented this cycle
line_sync  input  1  qualifies the presented pixel as first of a line; ignored when pixel_valid=0
frame_sync  input  1  qualifies the presented pixel as first of a frame; overrides line_sync; ignored when pixel_valid=0
x  output  X_WIDTH  column of last accepted pixel
y  output  Y_WIDTH  row of last accepted pixel
pix_strobe  output  1  one-cycle pulse: x/y updated
line_end  output  1  pulse: last accepted pixel had x = LINE_PIXELS-1
frame_end  output  1  pulse: last accepted pixel was (LINE_PIXELS-1, FRAME_LINES-1)
window_valid  output  1  pulse: last accepted pixel completes a census window
center_x  output  X_WIDTH  window centre column (x-R)
center_y  output  Y_WIDTH  window centre row (y-R)
overrun  output  1  sticky: a frame exceeded FRAME_LINES (AUTO_WRAP=0 only)

Behaviour:
- Reset (async, any time, including mid-line): internal next-coordinates nx=0, ny=0. All outputs are 0.
- Accept: a pixel is accepted on each rising edge with pixel_valid=1. With pixel_valid=0, nothing changes except that the pulse outputs drop to 0.
- Coordinate (cx,cy) assigned to an accepted pixel:
  - frame_sync=1: (0,0).
  - else line_sync=1: (0, ny) if nx==0, else (0, ny+1).
  - else: (nx, ny).
- Row overflow: whenever the computed row equals FRAME_LINES:
  - AUTO_WRAP=1: row becomes 0.
  - AUTO_WRAP=0: row held at FRAME_LINES-1 and overrun set.
- Next-coordinate update after accept:
  - cx==LINE_PIXELS-1: nx=0, ny=cy+1 (overflow rule above applied when consumed).
  - else: nx=cx+1, ny=cy.
- Outputs (registered, latency 1 cycle after the accept edge):
  - x<=cx, y<=cy, pix_strobe<=1.
  - line_end <= (cx==LINE_PIXELS-1).
  - frame_end <= line_end condition and (cy==FRAME_LINES-1).
  - window_valid <= (cx>=2R and cy>=2R).
  - center_x/center_y <= cx-R / cy-R only when window_valid is set; otherwise held.
- x, y, center_x and center_y hold between accepts.
- Short lines (line_sync before LINE_PIXELS pixels) produce no line_end.
- overrun: sticky. Cleared only by reset or by an accepted pixel carrying frame_sync; clearing takes effect on that same output update. Always 0 when AUTO_WRAP=1.
- frame_sync and line_sync asserted together: frame_sync wins.

Test Plan:
- LINE_PIXELS=4, FRAME_LINES=3, R=1, reset then 12 back-to-back valid pixels:
  - x cycles 0..3, y 0..2.
  - line_end after pixels 4, 8 and 12; frame_end only after pixel 12.
  - window_valid only for (2,2),(3,2), with centres (1,1),(2,1).
- Same config, pixel_valid toggled 1/0:
  - pix_strobe pulses only after valid cycles.
  - x/y hold during gaps, with no extra increments.
- 2 pixels, then a pixel with line_sync -> it reports (0,1); no line_end for the short line.
- frame_sync asserted on the pixel that would be (2,1) -> it reports (0,0) and the next plain pixel reports (1,0).
- AUTO_WRAP=0, 13 pixels without sync:
  - 13th pixel reports (0,2) and overrun=1.
  - Next frame_sync pixel reports (0,0) and overrun=0.
  - With AUTO_WRAP=1 the 13th pixel reports (0,0) and overrun stays 0.
- reset pulsed between clock edges mid-line -> all outputs 0 immediately; first pixel after release reports (0,0).
